// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequences PC updates, IF/ID latch control and
// redirect handling around a variable-latency instruction memory.
module fetch_ctrl #(
   parameter logic [29:0] START_ADDR = 30'h0000BFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [29:0] PC,
   input  logic        jmp,
   input  logic [29:0] jmp_target,
   input  logic        br_taken,
   input  logic [29:0] br_target,
   input  logic        hazard_stall,
   input  logic        imem_ready,
   output logic        imem_req,
   output logic [29:0] NPC,
   output logic        PCWrite,
   output logic        IFIDWrite,
   output logic        IFIDFlush,
   output logic [1:0]  state,
   output logic [31:0] fetch_cnt,
   output logic [15:0] stall_cnt
);

   typedef enum logic [1:0] {BOOT = 2'd0, FETCH = 2'd1, MEMWAIT = 2'd2, REDIR = 2'd3} state_t;

   state_t      st;
   logic [29:0] redir_q;
   logic        active;
   logic        redirect;
   logic        in_redir;
   logic [29:0] tgt;

   assign state = st;

   always_comb begin
      active    = (st != BOOT);
      in_redir  = (st == REDIR);
      redirect  = jmp | br_taken;
      tgt       = jmp ? jmp_target : br_target;
      imem_req  = active;
      PCWrite   = active & imem_ready & (~hazard_stall | redirect | in_redir);
      IFIDFlush = active & (redirect | (in_redir & imem_ready));
      IFIDWrite = active & imem_ready & ~hazard_stall & ~IFIDFlush;
      // A live redirect overrides a pending one; otherwise replay the latched target.
      if (redirect)
         NPC = tgt;
      else if (in_redir)
         NPC = redir_q;
      else
         NPC = PC + 30'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st        <= BOOT;
         redir_q   <= START_ADDR;
         fetch_cnt <= 32'd0;
         stall_cnt <= 16'd0;
      end else begin
         if (PCWrite)
            fetch_cnt <= fetch_cnt + 32'd1;
         if (active && !PCWrite && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;

         case (st)
            BOOT: st <= FETCH;
            FETCH, MEMWAIT: begin
               if (imem_ready) begin
                  st <= FETCH;
               end else if (redirect) begin
                  st      <= REDIR;
                  redir_q <= tgt;
               end else begin
                  st <= MEMWAIT;
               end
            end
            REDIR: begin
               // Hold the redirect until memory accepts; the newest target wins.
               if (imem_ready)
                  st <= FETCH;
               else if (redirect)
                  redir_q <= tgt;
            end
            default: st <= BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a per-cycle reference model checked on every falling
// edge, plus directed scenarios with hand-computed literal expectations.
module tb_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [29:0] pc;
   logic        jmp;
   logic [29:0] jmp_target;
   logic        br_taken;
   logic [29:0] br_target;
   logic        hazard_stall;
   logic        imem_ready;
   logic        imem_req;
   logic [29:0] npc;
   logic        pc_write;
   logic        ifid_write;
   logic        ifid_flush;
   logic [1:0]  state;
   logic [31:0] fetch_cnt;
   logic [15:0] stall_cnt;

   int checks = 0;
   int errors = 0;
   bit run = 1'b0;

   fetch_ctrl #(.START_ADDR(30'h0000BFF)) dut (
      .clk(clk), .reset(reset), .PC(pc),
      .jmp(jmp), .jmp_target(jmp_target),
      .br_taken(br_taken), .br_target(br_target),
      .hazard_stall(hazard_stall), .imem_ready(imem_ready),
      .imem_req(imem_req), .NPC(npc), .PCWrite(pc_write),
      .IFIDWrite(ifid_write), .IFIDFlush(ifid_flush),
      .state(state), .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   // Reference model: mode 0=boot,1=fetch,2=waiting,3=redirect pending.
   int          m_mode, n_mode;
   logic [29:0] m_pend, n_pend;
   logic [31:0] m_fetches, n_fetches;
   int          m_lost, n_lost;

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_mode = 0; m_pend = 30'h0000BFF; m_fetches = 0; m_lost = 0;
      end else begin
         m_mode = n_mode; m_pend = n_pend; m_fetches = n_fetches; m_lost = n_lost;
      end
   end

   always @(negedge clk) begin
      if (run) begin
         bit          live, redir, pending, e_pcw, e_flush, e_ifw;
         logic [29:0] target, e_npc;
         live    = reset && (m_mode != 0);
         redir   = jmp || br_taken;
         target  = jmp ? jmp_target : br_target;
         pending = (m_mode == 3);
         e_pcw   = live && imem_ready && (!hazard_stall || redir || pending);
         e_flush = live && (redir || (pending && imem_ready));
         e_ifw   = live && imem_ready && !hazard_stall && !e_flush;
         e_npc   = redir ? target : (pending ? m_pend : 30'(pc + 1));
         cmp("imem_req",  32'(imem_req),   32'(live));
         cmp("PCWrite",   32'(pc_write),   32'(e_pcw));
         cmp("IFIDFlush", 32'(ifid_flush), 32'(e_flush));
         cmp("IFIDWrite", 32'(ifid_write), 32'(e_ifw));
         cmp("NPC",       32'(npc),        32'(e_npc));
         cmp("state",     32'(state),      32'(m_mode));
         cmp("fetch_cnt", fetch_cnt,       m_fetches);
         cmp("stall_cnt", 32'(stall_cnt),  32'(m_lost));
         n_pend = m_pend;
         if (!reset) begin
            n_mode = 0; n_pend = 30'h0000BFF; n_fetches = 0; n_lost = 0;
         end else begin
            if (m_mode == 0)      n_mode = 1;
            else if (imem_ready)  n_mode = 1;
            else if (redir) begin n_mode = 3; n_pend = target; end
            else                  n_mode = pending ? 3 : 2;
            n_fetches = m_fetches + (e_pcw ? 32'd1 : 32'd0);
            n_lost    = (live && !e_pcw && m_lost < 65535) ? m_lost + 1 : m_lost;
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      jmp = 0; br_taken = 0; hazard_stall = 0;
      jmp_target = 30'h0; br_target = 30'h0;
   endtask

   initial begin
      reset = 1'b1; pc = 30'h0000BFF; imem_ready = 1'b1;
      idle_inputs();
      #2 reset = 1'b0;
      run = 1'b1;
      cyc(); cyc(); #3;
      cmp("rst_state", 32'(state), 32'd0);
      cmp("rst_imem_req", 32'(imem_req), 32'd0);
      cmp("rst_pcwrite", 32'(pc_write), 32'd0);

      // Boot sequence from START_ADDR
      cyc(); reset = 1'b1; #3;
      cmp("boot_state", 32'(state), 32'd0);
      cmp("boot_pcwrite", 32'(pc_write), 32'd0);
      cyc(); #3;
      cmp("fetch_state", 32'(state), 32'd1);
      cmp("fetch_pcwrite", 32'(pc_write), 32'd1);
      cmp("fetch_npc", 32'(npc), 32'h0000C00);
      cyc(); #3;
      cmp("fetch_cnt_1", fetch_cnt, 32'd1);

      // Two-cycle load-use stall
      cyc(); hazard_stall = 1; #3;
      cmp("stall1_pcwrite", 32'(pc_write), 32'd0);
      cmp("stall1_ifidwrite", 32'(ifid_write), 32'd0);
      cyc(); #3;
      cmp("stall2_pcwrite", 32'(pc_write), 32'd0);
      cmp("stall2_state", 32'(state), 32'd1);
      cyc(); hazard_stall = 0; #3;
      cmp("stall_cnt_2", 32'(stall_cnt), 32'd2);
      cmp("stall_state", 32'(state), 32'd1);

      // Branch while memory busy, replayed three cycles later
      cyc(); imem_ready = 0; br_taken = 1; br_target = 30'h100; #3;
      cmp("br_flush", 32'(ifid_flush), 32'd1);
      cmp("br_pcwrite", 32'(pc_write), 32'd0);
      cyc(); idle_inputs(); pc = 30'h555; #3;
      cmp("redir_state", 32'(state), 32'd3);
      cmp("redir_flush_wait", 32'(ifid_flush), 32'd0);
      cyc(); cyc(); imem_ready = 1; #3;
      cmp("replay_npc", 32'(npc), 32'h100);
      cmp("replay_pcwrite", 32'(pc_write), 32'd1);
      cmp("replay_flush", 32'(ifid_flush), 32'd1);
      cyc(); #3;
      cmp("replay_state", 32'(state), 32'd1);

      // jmp beats br_taken, redirect beats hazard_stall
      cyc(); jmp = 1; jmp_target = 30'h200; br_taken = 1; br_target = 30'h300;
      hazard_stall = 1; #3;
      cmp("prio_npc", 32'(npc), 32'h200);
      cmp("prio_pcwrite", 32'(pc_write), 32'd1);
      cmp("prio_flush", 32'(ifid_flush), 32'd1);
      cmp("prio_ifidwrite", 32'(ifid_write), 32'd0);

      // Newest redirect wins while pending
      cyc(); idle_inputs(); imem_ready = 0; jmp = 1; jmp_target = 30'h400;
      cyc(); idle_inputs(); br_taken = 1; br_target = 30'h500;
      cyc(); idle_inputs(); imem_ready = 1; #3;
      cmp("latest_npc", 32'(npc), 32'h500);

      // PC wrap and stall counter saturation
      cyc(); pc = 30'h3FFFFFFF; #3;
      cmp("wrap_npc", 32'(npc), 32'h0);
      cyc(); imem_ready = 0; pc = 30'h10;
      cyc(); #3;
      cmp("memwait_state", 32'(state), 32'd2);
      for (int i = 0; i < 65540; i++) cyc();
      #3;
      cmp("sat_stall_cnt", 32'(stall_cnt), 32'hFFFF);
      cyc(); cyc(); #3;
      cmp("sat_hold", 32'(stall_cnt), 32'hFFFF);

      // Reset while a redirect is pending
      cyc(); imem_ready = 1;
      cyc(); imem_ready = 0; br_taken = 1; br_target = 30'h100;
      cyc(); idle_inputs(); #3;
      cmp("pre_rst_state", 32'(state), 32'd3);
      cyc(); reset = 1'b0; imem_ready = 1; pc = 30'h123; #1;
      cmp("async_imem_req", 32'(imem_req), 32'd0);
      cmp("async_pcwrite", 32'(pc_write), 32'd0);
      cmp("async_flush", 32'(ifid_flush), 32'd0);
      cmp("async_state", 32'(state), 32'd0);
      cmp("async_stall_cnt", 32'(stall_cnt), 32'd0);
      cmp("async_fetch_cnt", fetch_cnt, 32'd0);
      cyc(); cyc(); reset = 1'b1; #3;
      cmp("post_boot", 32'(state), 32'd0);
      cyc(); #3;
      cmp("post_fetch", 32'(state), 32'd1);
      cmp("post_npc", 32'(npc), 32'h124);
      cmp("post_flush", 32'(ifid_flush), 32'd0);
      cyc(); cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
